// File: rtl/if_stage_if.sv
// ----------------------------------------------------------------------------
// if_stage_if
// Instruction-memory fetch bus used by the RV32I instruction-fetch stage.
// Pipelined request/grant/response protocol:
//   IMEM_REQ    fetch side -> memory : a fetch request is presented
//   IMEM_ADDR   fetch side -> memory : word-aligned fetch address
//   IMEM_GNT    memory -> fetch side : request accepted this cycle
//   IMEM_RVALID memory -> fetch side : response valid (in order, >=1 cycle
//                                      after its grant)
//   IMEM_RDATA  memory -> fetch side : response instruction word
// Modports: master (fetch stage), slave (instruction memory).
// ----------------------------------------------------------------------------
interface if_stage_if;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_GNT;
   logic        IMEM_RVALID;
   logic [31:0] IMEM_RDATA;

   modport master (
      output IMEM_REQ,
      output IMEM_ADDR,
      input  IMEM_GNT,
      input  IMEM_RVALID,
      input  IMEM_RDATA
   );

   modport slave (
      input  IMEM_REQ,
      input  IMEM_ADDR,
      output IMEM_GNT,
      output IMEM_RVALID,
      output IMEM_RDATA
   );
endinterface

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the RV32I core. Owns the PC, issues fetches on
// the pipelined instruction-memory bus, buffers returned words in a 2-entry
// FIFO and presents one instruction at a time to decode via the IF/ID
// register.
// Ports:
//   CLK, RST_N        clock (rising edge) and asynchronous active-low reset
//   imem              if_stage_if.master instruction-memory bus
//   REDIRECT          taken branch/jump from execute (highest priority)
//   REDIRECT_PC       redirect target (low two bits ignored)
//   STALL             decode cannot accept; IF/ID holds
//   INSTRUCCION       IF/ID instruction (NOP_INSTR when not valid)
//   PC_ID, PC4_ID     PC of INSTRUCCION and PC_ID+4
//   VALID_ID          IF/ID holds a live instruction
// Optional feature (macro IF_STATS_EN):
//   FETCH_CNT         count of FIFO pops into IF/ID (wrapping)
//   BUBBLE_CNT        count of non-stalled cycles with an empty FIFO (wrapping)
// ----------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RST_N,
   if_stage_if.master  imem,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_PC,
   input  logic        STALL,
   output logic [31:0] INSTRUCCION,
   output logic [31:0] PC_ID,
   output logic [31:0] PC4_ID,
`ifdef IF_STATS_EN
   output logic [31:0] FETCH_CNT,
   output logic [31:0] BUBBLE_CNT,
`endif
   output logic        VALID_ID
);

   logic [31:0] pc_q, pc_d;
   logic [1:0]  outst_q, outst_d;
   logic [1:0]  kill_q, kill_d;
   logic [31:0] tag_pc_q [0:1];
   logic [31:0] tag_pc_d [0:1];
   logic        tag_wr_ptr_q, tag_wr_ptr_d, tag_rd_ptr_q, tag_rd_ptr_d;
   logic [31:0] fifo_word_q [0:1];
   logic [31:0] fifo_word_d [0:1];
   logic [31:0] fifo_pc_q [0:1];
   logic [31:0] fifo_pc_d [0:1];
   logic        fifo_wr_ptr_q, fifo_wr_ptr_d, fifo_rd_ptr_q, fifo_rd_ptr_d;
   logic [1:0]  fifo_cnt_q, fifo_cnt_d;
   logic [31:0] instr_q, instr_d, pc_id_q, pc_id_d, pc4_id_q, pc4_id_d;
   logic        valid_id_q, valid_id_d;

   logic [2:0]  occupancy;
   logic [31:0] redirect_target;
   logic        req, grant, rvalid, push_en, pop_en;

   // Capacity counts only registered state (in flight + buffered), so STALL
   // never reaches IMEM_REQ combinationally and the FIFO cannot overflow.
   always_comb begin
      occupancy       = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
      redirect_target = REDIRECT_PC & 32'hFFFF_FFFC;
      req             = !REDIRECT && (occupancy < 3'd2);
      grant           = req && imem.IMEM_GNT;
      rvalid          = imem.IMEM_RVALID;
      push_en         = rvalid && !REDIRECT && (kill_q == 2'd0);
      pop_en          = !REDIRECT && !STALL && (fifo_cnt_q != 2'd0);
   end

   assign imem.IMEM_REQ  = req;
   assign imem.IMEM_ADDR = pc_q;

   // PC, outstanding/kill counters and the PC tag shadow. Tags are popped by
   // every response, killed or not, so the shadow stays aligned with OUTST
   // across redirects without needing its own flush.
   always_comb begin
      pc_d         = pc_q;
      outst_d      = outst_q;
      kill_d       = kill_q;
      tag_pc_d     = tag_pc_q;
      tag_wr_ptr_d = tag_wr_ptr_q;
      tag_rd_ptr_d = tag_rd_ptr_q;
      if (grant && !rvalid)
         outst_d = outst_q + 2'd1;
      else if (!grant && rvalid)
         outst_d = outst_q - 2'd1;
      if (grant) begin
         pc_d                   = pc_q + 32'd4;
         tag_pc_d[tag_wr_ptr_q] = pc_q;
         tag_wr_ptr_d           = !tag_wr_ptr_q;
      end
      if (rvalid)
         tag_rd_ptr_d = !tag_rd_ptr_q;
      if (REDIRECT) begin
         pc_d   = redirect_target;
         kill_d = outst_q - {1'b0, rvalid};
      end else if (rvalid && (kill_q != 2'd0)) begin
         kill_d = kill_q - 2'd1;
      end
   end

   // Response FIFO of {word, pc}; a redirect empties it in the same cycle.
   always_comb begin
      fifo_word_d   = fifo_word_q;
      fifo_pc_d     = fifo_pc_q;
      fifo_wr_ptr_d = fifo_wr_ptr_q;
      fifo_rd_ptr_d = fifo_rd_ptr_q;
      fifo_cnt_d    = fifo_cnt_q;
      if (REDIRECT) begin
         fifo_wr_ptr_d = 1'b0;
         fifo_rd_ptr_d = 1'b0;
         fifo_cnt_d    = 2'd0;
      end else begin
         if (push_en) begin
            fifo_word_d[fifo_wr_ptr_q] = imem.IMEM_RDATA;
            fifo_pc_d[fifo_wr_ptr_q]   = tag_pc_q[tag_rd_ptr_q];
            fifo_wr_ptr_d              = !fifo_wr_ptr_q;
         end
         if (pop_en)
            fifo_rd_ptr_d = !fifo_rd_ptr_q;
         if (push_en && !pop_en)
            fifo_cnt_d = fifo_cnt_q + 2'd1;
         else if (!push_en && pop_en)
            fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
   end

   // IF/ID register: redirect bubbles it, stall holds it, otherwise it takes
   // the FIFO head or goes to a NOP bubble while keeping the last PC.
   always_comb begin
      instr_d    = instr_q;
      pc_id_d    = pc_id_q;
      pc4_id_d   = pc4_id_q;
      valid_id_d = valid_id_q;
      if (REDIRECT) begin
         instr_d    = NOP_INSTR;
         valid_id_d = 1'b0;
      end else if (!STALL) begin
         if (fifo_cnt_q != 2'd0) begin
            instr_d    = fifo_word_q[fifo_rd_ptr_q];
            pc_id_d    = fifo_pc_q[fifo_rd_ptr_q];
            pc4_id_d   = fifo_pc_q[fifo_rd_ptr_q] + 32'd4;
            valid_id_d = 1'b1;
         end else begin
            instr_d    = NOP_INSTR;
            valid_id_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pc_q           <= RESET_PC;
         outst_q        <= 2'd0;
         kill_q         <= 2'd0;
         tag_pc_q[0]    <= 32'd0;
         tag_pc_q[1]    <= 32'd0;
         tag_wr_ptr_q   <= 1'b0;
         tag_rd_ptr_q   <= 1'b0;
         fifo_word_q[0] <= 32'd0;
         fifo_word_q[1] <= 32'd0;
         fifo_pc_q[0]   <= 32'd0;
         fifo_pc_q[1]   <= 32'd0;
         fifo_wr_ptr_q  <= 1'b0;
         fifo_rd_ptr_q  <= 1'b0;
         fifo_cnt_q     <= 2'd0;
         instr_q        <= NOP_INSTR;
         pc_id_q        <= 32'd0;
         pc4_id_q       <= 32'd0;
         valid_id_q     <= 1'b0;
      end else begin
         pc_q           <= pc_d;
         outst_q        <= outst_d;
         kill_q         <= kill_d;
         tag_pc_q       <= tag_pc_d;
         tag_wr_ptr_q   <= tag_wr_ptr_d;
         tag_rd_ptr_q   <= tag_rd_ptr_d;
         fifo_word_q    <= fifo_word_d;
         fifo_pc_q      <= fifo_pc_d;
         fifo_wr_ptr_q  <= fifo_wr_ptr_d;
         fifo_rd_ptr_q  <= fifo_rd_ptr_d;
         fifo_cnt_q     <= fifo_cnt_d;
         instr_q        <= instr_d;
         pc_id_q        <= pc_id_d;
         pc4_id_q       <= pc4_id_d;
         valid_id_q     <= valid_id_d;
      end
   end

   assign INSTRUCCION = instr_q;
   assign PC_ID       = pc_id_q;
   assign PC4_ID      = pc4_id_q;
   assign VALID_ID    = valid_id_q;

`ifdef IF_STATS_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d, bubble_cnt_q, bubble_cnt_d;

   // Pops into IF/ID and empty non-stalled cycles, both free-running.
   always_comb begin
      fetch_cnt_d  = fetch_cnt_q + {31'd0, pop_en};
      bubble_cnt_d = bubble_cnt_q + {31'd0, (!STALL && (fifo_cnt_q == 2'd0))};
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fetch_cnt_q  <= 32'd0;
         bubble_cnt_q <= 32'd0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign FETCH_CNT  = fetch_cnt_q;
   assign BUBBLE_CNT = bubble_cnt_q;
`endif

   // A push into a full FIFO without a simultaneous pop is a design error.
   a_fifo_no_overflow : assert property (@(posedge CLK) disable iff (!RST_N)
      !(push_en && !pop_en && (fifo_cnt_q == 2'd2)));

endmodule
